// File: rtl/ltssm_dir_scheduler.sv
// Link direction scheduler: holds TX or RX ownership with dwell/quota
// fairness and drives a registered RX request through turnaround states.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   tx_pending, rx_pending     traffic waiting on each side
//   rx_ack, occupied           direction arbiter status
//   cfg_min_dwell              minimum cycles held before a switch
//   cfg_max_quota              cycles after which a pending peer forces a switch
//   rx_req                     registered request to the arbiter
//   cur_dir                    settled direction (0 TX, 1 RX)
//   switching                  in a turnaround state
//   turn_err                   sticky turnaround timeout flag
//   turn_cnt                   completed turnarounds (wrapping)
module ltssm_dir_scheduler #(
   parameter int TO_CYC = 64,
   parameter int CW     = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tx_pending,
   input  logic          rx_pending,
   input  logic          rx_ack,
   input  logic          occupied,
   input  logic [CW-1:0] cfg_min_dwell,
   input  logic [CW-1:0] cfg_max_quota,
   output logic          rx_req,
   output logic          cur_dir,
   output logic          switching,
   output logic          turn_err,
   output logic [15:0]   turn_cnt
);

   localparam int WW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TO_CYC - 1);

   typedef enum logic [1:0] {
      TX_HOLD,
      REQ_RX,
      RX_HOLD,
      REL_RX
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] dwell_q;
   logic [WW-1:0] wait_q;
   logic          rx_req_q;
   logic          err_q;
   logic [15:0]   turn_cnt_q;
   logic          err_set;
   logic          turn_inc;
   logic          dwell_ok;
   logic          quota_ok;
   logic          wait_last;

   assign dwell_ok  = (dwell_q >= cfg_min_dwell);
   assign quota_ok  = (dwell_q >= cfg_max_quota);
   assign wait_last = (wait_q == WAIT_LAST);

   always_comb begin
      state_d  = state_q;
      err_set  = 1'b0;
      turn_inc = 1'b0;
      unique case (state_q)
         TX_HOLD: begin
            if (rx_pending && dwell_ok && (!tx_pending || quota_ok))
               state_d = REQ_RX;
         end
         REQ_RX: begin
            if (rx_ack) begin
               state_d  = RX_HOLD;
               turn_inc = 1'b1;
            end else if (wait_last) begin
               // Abandon the request; release path returns to TX.
               state_d = REL_RX;
               err_set = 1'b1;
            end
         end
         RX_HOLD: begin
            if (dwell_ok && (!rx_pending || (tx_pending && quota_ok)))
               state_d = REL_RX;
         end
         REL_RX: begin
            // A clean release wins over a coincident timeout.
            if (!rx_ack && !occupied) begin
               state_d  = TX_HOLD;
               turn_inc = 1'b1;
            end else if (wait_last) begin
               state_d = TX_HOLD;
               err_set = 1'b1;
            end
         end
         default: state_d = TX_HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= TX_HOLD;
         dwell_q    <= '0;
         wait_q     <= '0;
         rx_req_q   <= 1'b0;
         err_q      <= 1'b0;
         turn_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         rx_req_q <= (state_d == REQ_RX) || (state_d == RX_HOLD);
         if (state_d != state_q) begin
            dwell_q <= '0;
            wait_q  <= '0;
         end else if ((state_q == TX_HOLD) || (state_q == RX_HOLD)) begin
            if (dwell_q != '1)
               dwell_q <= dwell_q + 1'b1;
         end else begin
            wait_q <= wait_q + 1'b1;
         end
         if (err_set)
            err_q <= 1'b1;
         if (turn_inc)
            turn_cnt_q <= turn_cnt_q + 16'd1;
      end
   end

   assign rx_req    = rx_req_q;
   assign cur_dir   = (state_q == RX_HOLD);
   assign switching = (state_q == REQ_RX) || (state_q == REL_RX);
   assign turn_err  = err_q;
   assign turn_cnt  = turn_cnt_q;

endmodule

// File: tb/tb_ltssm_dir_scheduler.sv
// Directed testbench for ltssm_dir_scheduler.
// Each task drives one scenario and checks hand-computed values.
module tb_ltssm_dir_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tx_pending;
   logic        rx_pending;
   logic        rx_ack;
   logic        occupied;
   logic [7:0]  cfg_min_dwell;
   logic [7:0]  cfg_max_quota;
   logic        rx_req;
   logic        cur_dir;
   logic        switching;
   logic        turn_err;
   logic [15:0] turn_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ltssm_dir_scheduler #(.TO_CYC(64), .CW(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_pending    (tx_pending),
      .rx_pending    (rx_pending),
      .rx_ack        (rx_ack),
      .occupied      (occupied),
      .cfg_min_dwell (cfg_min_dwell),
      .cfg_max_quota (cfg_max_quota),
      .rx_req        (rx_req),
      .cur_dir       (cur_dir),
      .switching     (switching),
      .turn_err      (turn_err),
      .turn_cnt      (turn_cnt)
   );

   // Arbiter model: acknowledge follows the request one half-cycle later.
   task automatic step();
      @(negedge clk);
      rx_ack = rx_req;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tx_pending = 1'b0;
      rx_pending = 1'b0;
      rx_ack = 1'b0;
      occupied = 1'b0;
      cfg_min_dwell = 8'd4;
      cfg_max_quota = 8'd8;
      #23;
      total++;
      if ({rx_req, cur_dir, switching, turn_err} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=0000",
                  {rx_req, cur_dir, switching, turn_err});
      end
      total++;
      if (turn_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_cnt got=%0d want=0", turn_cnt);
      end
   endtask

   task automatic test_min_dwell();
      rx_pending = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         if (k == 4) begin
            total++;
            if (rx_req !== 1'b0) begin
               bad++;
               $display("FAIL dwell_edge4 rx_req got=%b want=0", rx_req);
            end
         end
      end
      total++;
      if ({rx_req, switching} !== 2'b11) begin
         bad++;
         $display("FAIL dwell_edge5 req/sw got=%b want=11",
                  {rx_req, switching});
      end
      @(negedge clk);
      rx_ack = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({cur_dir, switching} !== 2'b10 || turn_cnt !== 16'd1) begin
         bad++;
         $display("FAIL dwell_rxhold dir/sw=%b cnt=%0d want 10 cnt=1",
                  {cur_dir, switching}, turn_cnt);
      end
   endtask

   task automatic test_release_occupied();
      int n;
      int hold_bad;
      @(negedge clk);
      rx_pending = 1'b0;
      occupied = 1'b1;
      n = 0;
      while (!switching && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (n != 5 || rx_req !== 1'b0 || cur_dir !== 1'b0) begin
         bad++;
         $display("FAIL rel_entry n=%0d req=%b dir=%b want n=5 req=0 dir=0",
                  n, rx_req, cur_dir);
      end
      @(negedge clk);
      rx_ack = 1'b0;
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (switching !== 1'b1) hold_bad++;
      end
      total++;
      if (hold_bad != 0) begin
         bad++;
         $display("FAIL rel_hold early_exit_cycles=%0d want=0", hold_bad);
      end
      @(negedge clk);
      occupied = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({switching, cur_dir, turn_err} !== 3'b000 ||
          turn_cnt !== 16'd2) begin
         bad++;
         $display("FAIL rel_done sw/dir/err=%b cnt=%0d want 000 cnt=2",
                  {switching, cur_dir, turn_err}, turn_cnt);
      end
   endtask

   task automatic test_alternate();
      int n;
      cfg_min_dwell = 8'd2;
      cfg_max_quota = 8'd6;
      tx_pending = 1'b1;
      rx_pending = 1'b1;
      n = 0;
      while (!cur_dir && n < 40) begin
         step();
         n++;
      end
      total++;
      if (cur_dir !== 1'b1 || turn_cnt !== 16'd3) begin
         bad++;
         $display("FAIL alt_sync dir=%b cnt=%0d want dir=1 cnt=3",
                  cur_dir, turn_cnt);
      end
      for (int r = 0; r < 2; r++) begin
         n = 0;
         while (cur_dir && n < 50) begin
            step();
            n++;
         end
         total++;
         if (n != 7 || switching !== 1'b1) begin
            bad++;
            $display("FAIL alt_rx_len r=%0d got=%0d sw=%b want=7 sw=1",
                     r, n, switching);
         end
         step();
         n = 0;
         while (!switching && n < 50) begin
            step();
            n++;
         end
         total++;
         if (n != 7) begin
            bad++;
            $display("FAIL alt_tx_len r=%0d got=%0d want=7", r, n);
         end
         step();
         total++;
         if (cur_dir !== 1'b1 || turn_cnt !== 16'(5 + 2 * r)) begin
            bad++;
            $display("FAIL alt_cnt r=%0d dir=%b cnt=%0d want dir=1 cnt=%0d",
                     r, cur_dir, turn_cnt, 5 + 2 * r);
         end
      end
   endtask

   task automatic test_zero_cfg();
      int n;
      cfg_min_dwell = 8'd0;
      cfg_max_quota = 8'd0;
      n = 0;
      while (cur_dir && n < 10) begin
         step();
         n++;
      end
      total++;
      if (n != 1) begin
         bad++;
         $display("FAIL zero_rx_len got=%0d want=1", n);
      end
      step();
      total++;
      if (turn_cnt !== 16'd8 || switching !== 1'b0) begin
         bad++;
         $display("FAIL zero_cnt cnt=%0d sw=%b want cnt=8 sw=0",
                  turn_cnt, switching);
      end
      n = 0;
      while (!switching && n < 10) begin
         step();
         n++;
      end
      total++;
      if (n != 1) begin
         bad++;
         $display("FAIL zero_tx_len got=%0d want=1", n);
      end
   endtask

   // Entered in REQ_RX with rx_ack low; the arbiter never answers.
   task automatic test_timeout();
      int early;
      early = 0;
      for (int i = 1; i <= 63; i++) begin
         @(posedge clk);
         #1;
         if (rx_req !== 1'b1 || turn_err !== 1'b0) early++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL to_early bad_cycles=%0d want=0", early);
      end
      @(posedge clk);
      #1;
      total++;
      if ({turn_err, rx_req, switching, cur_dir} !== 4'b1010) begin
         bad++;
         $display("FAIL to_fire err/req/sw/dir=%b want=1010",
                  {turn_err, rx_req, switching, cur_dir});
      end
      @(negedge clk);
      rx_pending = 1'b0;
      tx_pending = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({switching, cur_dir, turn_err} !== 3'b001 ||
          turn_cnt !== 16'd9) begin
         bad++;
         $display("FAIL to_back sw/dir/err=%b cnt=%0d want 001 cnt=9",
                  {switching, cur_dir, turn_err}, turn_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      rx_pending = 1'b1;
      n = 0;
      while (!cur_dir && n < 10) begin
         step();
         n++;
      end
      total++;
      if (cur_dir !== 1'b1) begin
         bad++;
         $display("FAIL mid_reach dir=%b want=1", cur_dir);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({rx_req, cur_dir, switching, turn_err} !== 4'b0000 ||
          turn_cnt !== 16'd0) begin
         bad++;
         $display("FAIL mid_reset flags=%b cnt=%0d want 0000 cnt=0",
                  {rx_req, cur_dir, switching, turn_err}, turn_cnt);
      end
      @(negedge clk);
      rx_pending = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({rx_req, cur_dir, switching} !== 3'b000) begin
         bad++;
         $display("FAIL mid_resume req/dir/sw=%b want=000 (rx_ack=%b)",
                  {rx_req, cur_dir, switching}, rx_ack);
      end
   endtask

   task automatic test_wrap();
      int n;
      @(negedge clk);
      rx_ack = 1'b0;
      force dut.turn_cnt_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release dut.turn_cnt_q;
      @(posedge clk);
      #1;
      total++;
      if (turn_cnt !== 16'hFFFE) begin
         bad++;
         $display("FAIL wrap_preload got=%h want=fffe", turn_cnt);
      end
      rx_pending = 1'b1;
      n = 0;
      while (!cur_dir && n < 10) begin
         step();
         n++;
      end
      total++;
      if (turn_cnt !== 16'hFFFF || cur_dir !== 1'b1) begin
         bad++;
         $display("FAIL wrap_ffff cnt=%h dir=%b want ffff dir=1",
                  turn_cnt, cur_dir);
      end
      rx_pending = 1'b0;
      n = 0;
      while ((cur_dir || switching) && n < 10) begin
         step();
         n++;
      end
      total++;
      if (turn_cnt !== 16'h0000 ||
          {turn_err, rx_req, cur_dir, switching} !== 4'b0000) begin
         bad++;
         $display("FAIL wrap_zero cnt=%h flags=%b want 0000 flags=0000",
                  turn_cnt, {turn_err, rx_req, cur_dir, switching});
      end
   endtask

   initial begin
      test_reset();
      test_min_dwell();
      test_release_occupied();
      test_alternate();
      test_zero_cfg();
      test_timeout();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ltssm_dir_scheduler.md
LTSSM_DIR_SCHEDULER -- requirements
Module: ltssm_dir_scheduler

Interface
REQ-001 SHALL provide parameters: TO_CYC, default 64, turnaround timeout in clk cycles; CW, default 8, width of dwell/quota counters and configuration inputs.
REQ-002 SHALL provide port clk, input, 1, single clock; all logic is rising-edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port tx_pending, input, 1, local TX traffic waiting.
REQ-005 SHALL provide port rx_pending, input, 1, remote side requests the bus for RX.
REQ-006 SHALL provide port rx_ack, input, 1, direction arbiter is in RX ownership.
REQ-007 SHALL provide port occupied, input, 1, direction arbiter is draining or flushing.
REQ-008 SHALL provide port cfg_min_dwell, input, CW, minimum cycles held in a direction before a switch.
REQ-009 SHALL provide port cfg_max_quota, input, CW, cycles after which the opposite pending side forces a switch.
REQ-010 SHALL provide port rx_req, output, 1, registered request to the direction arbiter.
REQ-011 SHALL provide port cur_dir, output, 1, settled direction: 0 = TX, 1 = RX.
REQ-012 SHALL provide port switching, output, 1, high in any turnaround state.
REQ-013 SHALL provide port turn_err, output, 1, sticky; set on turnaround timeout.
REQ-014 SHALL provide port turn_cnt, output, 16, count of completed turnarounds; wraps 0xFFFF->0.

Function
REQ-015 SHALL implement four registered states: TX_HOLD, REQ_RX, RX_HOLD, REL_RX.
REQ-016 SHALL keep a saturating CW-bit dwell counter: cleared on every state entry, incremented each cycle in TX_HOLD/RX_HOLD, held at all-ones.
REQ-017 SHALL keep a TO_CYC-range wait counter: cleared on entry to REQ_RX/REL_RX, incremented each cycle in those states.
REQ-018 TX_HOLD -> REQ_RX SHALL occur when rx_pending and dwell >= cfg_min_dwell and (!tx_pending or dwell >= cfg_max_quota).
REQ-019 RX_HOLD -> REL_RX SHALL occur when dwell >= cfg_min_dwell and (!rx_pending or (tx_pending and dwell >= cfg_max_quota)).
REQ-020 REQ_RX -> RX_HOLD SHALL occur on the first cycle rx_ack = 1; turn_cnt increments on that transition.
REQ-021 REL_RX -> TX_HOLD SHALL occur on the first cycle rx_ack = 0 and occupied = 0; turn_cnt increments on that transition.
REQ-022 If the wait counter reaches TO_CYC-1 in REQ_RX, SHALL set turn_err and go to REL_RX, abandoning the request.
REQ-023 If the wait counter reaches TO_CYC-1 in REL_RX, SHALL set turn_err and go to TX_HOLD.
REQ-024 When both REQ-021 and REQ-023 conditions hold in the same cycle, SHALL take REQ-021 and leave turn_err unchanged.
REQ-025 rx_req SHALL be a registered output: 1 in REQ_RX and RX_HOLD, 0 in TX_HOLD and REL_RX; it updates on the same edge as the state.
REQ-026 cur_dir SHALL be 1 only in RX_HOLD; switching SHALL be 1 in REQ_RX and REL_RX.
REQ-027 cfg inputs SHALL be sampled live each cycle; cfg_min_dwell = 0 means no minimum; cfg_max_quota = 0 means an immediate switch whenever the other side is pending.
REQ-028 turn_err SHALL clear only on reset.
REQ-029 Simultaneous tx_pending and rx_pending in TX_HOLD with quota expired SHALL favour RX; in RX_HOLD with quota expired SHALL favour TX.

Reset
REQ-030 On rst_n low, SHALL asynchronously force state TX_HOLD, all counters 0, rx_req 0, cur_dir 0, switching 0, turn_err 0, turn_cnt 0.
REQ-031 Reset asserted mid-turnaround SHALL drop rx_req immediately; after release, SHALL resume in TX_HOLD regardless of rx_ack.

Verification
REQ-032 Bench SHALL check: min_dwell=4, quota=8, rx_pending=1, tx_pending=0 from reset -> rx_req rises at the 5th edge after release, cur_dir=1 once rx_ack=1, turn_cnt=1.
REQ-033 Bench SHALL check: both pending, min_dwell=2, quota=6 -> direction alternates every 6 dwell cycles plus turnaround; turn_cnt increments twice per round.
REQ-034 Bench SHALL check: rx_ack held 0 with TO_CYC=64 -> turn_err=1 after 64 cycles in REQ_RX, rx_req falls, then state returns to TX_HOLD.
REQ-035 Bench SHALL check: RX_HOLD then rx_pending drops, with occupied high for 10 cycles -> REL_RX holds 10+ cycles, then TX_HOLD with cur_dir=0 and turn_err=0.
REQ-036 Bench SHALL check: rst_n pulsed low while in RX_HOLD -> rx_req=0 in the same cycle, all outputs 0, and turn_cnt wrap at 0xFFFF->0 with no side effects.
